counter_timer_arb: RTL and testbench

Arbiter/sequencer that shares one loadable up-counter (load/a/count interface, increments by 1 per clock, wraps at max) between two requesters as an interval timer.
- Each requester asks for an interval of L cycles.
- The block grants round-robin, loads the counter with the two's-complement start value, watches for terminal count, and pulses done to the owner.
- Sits beside the counter instance; the counter is external to this block.

---
 rtl/counter_timer_arb.sv | 113 +++++++++++
 tb/tb_counter_timer_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_timer_arb.sv
// Round-robin arbiter that lends one external loadable up-counter to two
// requesters as an interval timer, pulsing done to the owner at terminal count.
module counter_timer_arb #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [CW-1:0] len0,
  input  logic          req1,
  input  logic [CW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          busy,
  output logic          cnt_load,
  output logic [CW-1:0] cnt_a,
  input  logic [CW-1:0] cnt_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t        state, state_next;
  logic          gnt0_next, gnt1_next;
  logic          done0_next, done1_next;
  logic [CW-1:0] len_q, len_next;
  logic          rr, rr_next;
  logic          abort;

  // rr names the requester favoured when both ask in the same IDLE cycle.
  assign abort = (gnt0 && !req0) || (gnt1 && !req1);
  assign busy  = (state != IDLE);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    gnt0_next  = gnt0;
    gnt1_next  = gnt1;
    done0_next = 1'b0;
    done1_next = 1'b0;
    len_next   = len_q;
    rr_next    = rr;
    cnt_load   = 1'b0;
    cnt_a      = '0;

    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || !rr)) begin
          gnt0_next  = 1'b1;
          len_next   = len0;
          state_next = LOAD;
        end else if (req1) begin
          gnt1_next  = 1'b1;
          len_next   = len1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Loading -L makes the counter reach all-ones after exactly L counts.
        cnt_load   = 1'b1;
        cnt_a      = '0 - len_q;
        state_next = RUN;
      end
      RUN: begin
        if (cnt_count == '1) begin
          done0_next = gnt0;
          done1_next = gnt1;
          state_next = DONE;
        end else if (abort) begin
          gnt0_next  = 1'b0;
          gnt1_next  = 1'b0;
          rr_next    = gnt0;
          state_next = IDLE;
        end
      end
      DONE: begin
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        rr_next    = gnt0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      len_q <= '0;
      rr    <= 1'b0;
    end else begin
      state <= state_next;
      gnt0  <= gnt0_next;
      gnt1  <= gnt1_next;
      done0 <= done0_next;
      done1 <= done1_next;
      len_q <= len_next;
      rr    <= rr_next;
    end
  end

endmodule

// File: tb/tb_counter_timer_arb.sv
// Directed bench for counter_timer_arb with a behavioural counter beside it
// and a scoreboard of expected done pulses (requester, cycle).
module tb_counter_timer_arb;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [CW-1:0] len0 = '0;
  logic [CW-1:0] len1 = '0;
  logic          gnt0, gnt1, done0, done1, busy, cnt_load;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_count = '0;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int c0     = 0;

  typedef struct {
    bit who;
    int at;
  } exp_t;
  exp_t sb[$];

  counter_timer_arb #(.CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .len0      (len0),
    .req1      (req1),
    .len1      (len1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .busy      (busy),
    .cnt_load  (cnt_load),
    .cnt_a     (cnt_a),
    .cnt_count (cnt_count)
  );

  always #5 clk = ~clk;

  // External counter: load when asked, otherwise count up and wrap.
  always @(posedge clk) cnt_count <= cnt_load ? cnt_a : cnt_count + 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {26'b0, gnt0, gnt1, done0, done1, busy, cnt_load}, 32'h0);
    check({tag, "_cnt_a"}, cnt_a, 32'h0);
  endtask

  task automatic expect_done(input bit who, input int at);
    exp_t e;
    e.who = who;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int   n = 0;
    exp_t e;
    while (!(done0 || done1) && n < budget) begin
      check("gnt_mutex", gnt0 & gnt1, 32'h0);
      tick();
      n++;
    end
    check("done_seen", done0 | done1, 32'h1);
    check("sb_nonempty", sb.size() != 0, 32'h1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("done_who", {done1, done0}, e.who ? 32'h2 : 32'h1);
      check("done_cycle", cyc, e.at);
      check("gnt_with_done", e.who ? gnt1 : gnt0, 32'h1);
    end
  endtask

  task automatic finish_done();
    tick();
    check("done_width", done0 | done1, 32'h0);
    check("gnt_release", gnt0 | gnt1, 32'h0);
    check("idle_after_done", busy, 32'h0);
  endtask

  initial begin
    // Reset held for two cycles, then idle with no requests.
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset_state");
    rst = 1'b0;
    tick();
    tick();
    check_idle("idle_no_req");

    // Requester 0, L=5: load 11, count 11..15, done at cycle 7.
    c0   = cyc;
    req0 = 1'b1;
    len0 = 4'd5;
    expect_done(1'b0, c0 + 7);
    tick();
    check("t2_gnt", {gnt0, gnt1}, 32'h2);
    check("t2_load", cnt_load, 32'h1);
    check("t2_cnt_a", cnt_a, 32'd11);
    check("t2_busy", busy, 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_count", cnt_count, 11 + k);
      check("t2_no_done", done0, 32'h0);
      check("t2_no_load", cnt_load, 32'h0);
    end
    wait_done(10);
    req0 = 1'b0;
    finish_done();

    // Boundary lengths on requester 1: L=1 and L=0 (meaning 16).
    c0   = cyc;
    req1 = 1'b1;
    len1 = 4'd1;
    expect_done(1'b1, c0 + 3);
    tick();
    check("t3_l1_cnt_a", cnt_a, 32'd15);
    check("t3_l1_gnt", {gnt0, gnt1}, 32'h1);
    wait_done(20);
    req1 = 1'b0;
    finish_done();

    c0   = cyc;
    req1 = 1'b1;
    len1 = 4'd0;
    expect_done(1'b1, c0 + 18);
    tick();
    check("t3_l0_cnt_a", cnt_a, 32'd0);
    check("t3_l0_load", cnt_load, 32'h1);
    wait_done(30);
    req1 = 1'b0;
    finish_done();

    // Both requesting from reset with L=2: grants alternate 0,1,0,1.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    c0   = cyc;
    req0 = 1'b1;
    req1 = 1'b1;
    len0 = 4'd2;
    len1 = 4'd2;
    expect_done(1'b0, c0 + 4);
    expect_done(1'b1, c0 + 9);
    expect_done(1'b0, c0 + 14);
    expect_done(1'b1, c0 + 19);
    for (int i = 0; i < 4; i++) begin
      wait_done(20);
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      finish_done();
    end

    // Abort: requester 0 drops mid-RUN while requester 1 waits.
    c0   = cyc;
    req0 = 1'b1;
    len0 = 4'd8;
    req1 = 1'b1;
    len1 = 4'd3;
    tick();
    check("t5_gnt0", {gnt0, gnt1}, 32'h2);
    tick();
    tick();
    tick();
    check("t5_running", {busy, gnt0}, 32'h3);
    req0 = 1'b0;
    tick();
    check("t5_abort_gnt", {gnt0, gnt1}, 32'h0);
    check("t5_abort_no_done", done0, 32'h0);
    check("t5_abort_idle", busy, 32'h0);
    expect_done(1'b1, c0 + 10);
    tick();
    check("t5_gnt1", {gnt0, gnt1}, 32'h1);
    check("t5_cnt_a", cnt_a, 32'd13);
    wait_done(20);
    req1 = 1'b0;
    finish_done();

    // Length change after grant is ignored.
    c0   = cyc;
    req0 = 1'b1;
    len0 = 4'd4;
    expect_done(1'b0, c0 + 6);
    tick();
    check("t6_cnt_a", cnt_a, 32'd12);
    tick();
    tick();
    len0 = 4'd9;
    wait_done(20);
    req0 = 1'b0;
    finish_done();

    // Reset mid-RUN aborts without a done pulse.
    req0 = 1'b1;
    len0 = 4'd5;
    tick();
    tick();
    tick();
    check("t1b_running", busy, 32'h1);
    rst  = 1'b1;
    req0 = 1'b0;
    tick();
    check_idle("t1b_reset_idle");
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1b_no_done", {gnt0, done0}, 32'h0);
    end
    check("sb_drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
